// File: rtl/chaining_record_tracker.sv
// Writer-side chaining records: one slot per in-flight vector-writing instruction,
// with a 128-element "already written" mask exported to the read-side checkers.
module chaining_record_slot (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         alloc_vd_valid,
  input  logic [4:0]   alloc_vd,
  input  logic [2:0]   alloc_inst,
  input  logic         fresh_set,
  input  logic [6:0]   fresh_rel,
  input  logic         write_valid,
  input  logic [4:0]   write_vd,
  input  logic [3:0]   write_offset,
  input  logic [2:0]   write_inst,
  input  logic         retire_valid,
  input  logic [2:0]   retire_inst,
  output logic         valid,
  output logic         vd_valid,
  output logic [4:0]   vd,
  output logic [2:0]   inst_index,
  output logic [127:0] mask,
  output logic         write_tag_hit,
  output logic         write_hit,
  output logic         retire_hit
);
  logic [8:0] rel;

  // 9-bit wrap is intentional: writes below the base land far above 127 and are dropped.
  assign rel           = {write_vd, write_offset} - {vd, 4'h0};
  assign write_tag_hit = write_valid & valid & vd_valid & (inst_index == write_inst);
  assign write_hit     = write_tag_hit & (rel < 9'd128);
  assign retire_hit    = retire_valid & valid & (inst_index == retire_inst);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid      <= 1'b0;
      vd_valid   <= 1'b0;
      vd         <= '0;
      inst_index <= '0;
      mask       <= '0;
    end else if (load) begin
      valid      <= 1'b1;
      vd_valid   <= alloc_vd_valid;
      vd         <= alloc_vd;
      inst_index <= alloc_inst;
      mask       <= fresh_set ? (128'd1 << fresh_rel) : '0;
    end else if (retire_hit) begin
      valid    <= 1'b0;
      vd_valid <= 1'b0;
      mask     <= '0;
    end else if (write_hit) begin
      mask[rel[6:0]] <= 1'b1;
    end
  end
endmodule

module chaining_record_tracker #(
  parameter int RECORDS = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  input  logic                   alloc_bits_vd_valid,
  input  logic [4:0]             alloc_bits_vd,
  input  logic [2:0]             alloc_bits_instIndex,
  input  logic                   write_valid,
  input  logic [4:0]             write_bits_vd,
  input  logic [3:0]             write_bits_offset,
  input  logic [2:0]             write_bits_instIndex,
  input  logic                   retire_valid,
  input  logic [2:0]             retire_bits_instIndex,
  output logic [RECORDS-1:0]     record_valid,
  output logic [RECORDS-1:0]     record_vd_valid,
  output logic [5*RECORDS-1:0]   record_vd,
  output logic [3*RECORDS-1:0]   record_instIndex,
  output logic [128*RECORDS-1:0] record_elementMask,
  output logic                   empty,
  output logic                   error
);
  logic [RECORDS-1:0] load, write_tag_hit, write_hit, retire_hit, dup;
  logic               alloc_fire, found, fresh_set, error_next;
  logic [8:0]         fresh_rel;

  assign alloc_ready = ~&record_valid;
  assign empty       = ~|record_valid;
  assign alloc_fire  = alloc_valid & alloc_ready;

  // A write racing the alloc of its own tag seeds the new slot's mask.
  assign fresh_rel = {write_bits_vd, write_bits_offset} - {alloc_bits_vd, 4'h0};
  assign fresh_set = alloc_fire & write_valid & alloc_bits_vd_valid &
                     (write_bits_instIndex == alloc_bits_instIndex) &
                     ~|write_tag_hit & (fresh_rel < 9'd128);

  always_comb begin
    load  = '0;
    found = 1'b0;
    for (int i = 0; i < RECORDS; i++) begin
      if (!record_valid[i] && !found) begin
        load[i] = alloc_fire;
        found   = 1'b1;
      end
    end
  end

  // A tag being retired this cycle is free for reuse, so it is not a duplicate.
  always_comb begin
    for (int i = 0; i < RECORDS; i++)
      dup[i] = record_valid[i] & ~retire_hit[i] &
               (record_instIndex[3*i +: 3] == alloc_bits_instIndex);
  end

  assign error_next = (alloc_fire & |dup) |
                      (write_valid & ~|write_hit & ~fresh_set) |
                      (retire_valid & ~|retire_hit);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          error <= 1'b0;
    else if (error_next) error <= 1'b1;
  end

  for (genvar i = 0; i < RECORDS; i++) begin : g_slot
    chaining_record_slot u_slot (
      .clock          (clock),
      .reset          (reset),
      .load           (load[i]),
      .alloc_vd_valid (alloc_bits_vd_valid),
      .alloc_vd       (alloc_bits_vd),
      .alloc_inst     (alloc_bits_instIndex),
      .fresh_set      (fresh_set),
      .fresh_rel      (fresh_rel[6:0]),
      .write_valid    (write_valid),
      .write_vd       (write_bits_vd),
      .write_offset   (write_bits_offset),
      .write_inst     (write_bits_instIndex),
      .retire_valid   (retire_valid),
      .retire_inst    (retire_bits_instIndex),
      .valid          (record_valid[i]),
      .vd_valid       (record_vd_valid[i]),
      .vd             (record_vd[5*i +: 5]),
      .inst_index     (record_instIndex[3*i +: 3]),
      .mask           (record_elementMask[128*i +: 128]),
      .write_tag_hit  (write_tag_hit[i]),
      .write_hit      (write_hit[i]),
      .retire_hit     (retire_hit[i])
    );
  end
endmodule

// File: tb/tb_chaining_record_tracker.sv
// Directed bench for chaining_record_tracker: per-cycle comparison against a
// slot-array model plus literal expectations from the hand-worked scenarios.
module tb_chaining_record_tracker;
  localparam int R = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic           alloc_valid, alloc_ready, alloc_bits_vd_valid;
  logic [4:0]     alloc_bits_vd;
  logic [2:0]     alloc_bits_instIndex;
  logic           write_valid;
  logic [4:0]     write_bits_vd;
  logic [3:0]     write_bits_offset;
  logic [2:0]     write_bits_instIndex;
  logic           retire_valid;
  logic [2:0]     retire_bits_instIndex;
  logic [R-1:0]   record_valid, record_vd_valid;
  logic [5*R-1:0] record_vd;
  logic [3*R-1:0] record_instIndex;
  logic [128*R-1:0] record_elementMask;
  logic           empty, error;

  chaining_record_tracker #(.RECORDS(R)) dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_bits_vd_valid(alloc_bits_vd_valid), .alloc_bits_vd(alloc_bits_vd),
    .alloc_bits_instIndex(alloc_bits_instIndex),
    .write_valid(write_valid), .write_bits_vd(write_bits_vd),
    .write_bits_offset(write_bits_offset), .write_bits_instIndex(write_bits_instIndex),
    .retire_valid(retire_valid), .retire_bits_instIndex(retire_bits_instIndex),
    .record_valid(record_valid), .record_vd_valid(record_vd_valid),
    .record_vd(record_vd), .record_instIndex(record_instIndex),
    .record_elementMask(record_elementMask), .empty(empty), .error(error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;
  bit checking = 0;

  // Model state
  logic         m_v[R], m_vdv[R];
  logic [4:0]   m_vd[R];
  logic [2:0]   m_tag[R];
  logic [127:0] m_mask[R];
  logic         m_err;

  function automatic int relof(int wvd, int off, int base);
    return (((wvd * 16 + off) - base * 16) % 512 + 512) % 512;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < R; i++) begin
      m_v[i] = 0; m_vdv[i] = 0; m_vd[i] = 0; m_tag[i] = 0; m_mask[i] = '0;
    end
    m_err = 0;
  endtask

  always @(negedge reset) model_clear();

  always @(posedge clock) begin : model_step
    bit ready, afire, wmatch, tagmatch, rhit, dupf, fresh;
    bit retired[R];
    int slot, r;
    if (reset === 1'b1) begin
      ready = 0; wmatch = 0; tagmatch = 0; rhit = 0; dupf = 0; fresh = 0; slot = -1;
      for (int i = 0; i < R; i++)
        if (!m_v[i]) begin ready = 1; if (slot < 0) slot = i; end
      afire = alloc_valid && ready;
      for (int i = 0; i < R; i++) begin
        retired[i] = retire_valid && m_v[i] && m_tag[i] == retire_bits_instIndex;
        if (retired[i]) rhit = 1;
        if (m_v[i] && !retired[i] && m_tag[i] == alloc_bits_instIndex) dupf = 1;
      end
      for (int i = 0; i < R; i++)
        if (write_valid && m_v[i] && m_vdv[i] && m_tag[i] == write_bits_instIndex) begin
          tagmatch = 1;
          r = relof(write_bits_vd, write_bits_offset, m_vd[i]);
          if (r < 128) begin m_mask[i][r] = 1'b1; wmatch = 1; end
        end
      for (int i = 0; i < R; i++)
        if (retired[i]) begin m_v[i] = 0; m_vdv[i] = 0; m_mask[i] = '0; end
      if (afire) begin
        m_v[slot] = 1; m_vdv[slot] = alloc_bits_vd_valid; m_vd[slot] = alloc_bits_vd;
        m_tag[slot] = alloc_bits_instIndex; m_mask[slot] = '0;
        if (write_valid && write_bits_instIndex == alloc_bits_instIndex && !tagmatch &&
            alloc_bits_vd_valid) begin
          r = relof(write_bits_vd, write_bits_offset, alloc_bits_vd);
          if (r < 128) begin m_mask[slot][r] = 1'b1; fresh = 1; end
        end
      end
      if ((afire && dupf) || (write_valid && !wmatch && !fresh) || (retire_valid && !rhit))
        m_err = 1;
    end
  end

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    logic any_free, any_valid;
    if (checking && reset === 1'b1) begin
      any_free = 0; any_valid = 0;
      for (int i = 0; i < R; i++) begin
        if (!m_v[i]) any_free = 1; else any_valid = 1;
        chk($sformatf("valid[%0d]", i), 128'(record_valid[i]), 128'(m_v[i]));
        chk($sformatf("vd_valid[%0d]", i), 128'(record_vd_valid[i]), 128'(m_vdv[i]));
        chk($sformatf("vd[%0d]", i), 128'(record_vd[5*i +: 5]), 128'(m_vd[i]));
        chk($sformatf("inst[%0d]", i), 128'(record_instIndex[3*i +: 3]), 128'(m_tag[i]));
        chk($sformatf("mask[%0d]", i), record_elementMask[128*i +: 128], m_mask[i]);
      end
      chk("alloc_ready", 128'(alloc_ready), 128'(any_free));
      chk("empty", 128'(empty), 128'(!any_valid));
      chk("error", 128'(error), 128'(m_err));
    end
  end

  task automatic idle();
    alloc_valid = 0; alloc_bits_vd_valid = 0; alloc_bits_vd = 0; alloc_bits_instIndex = 0;
    write_valid = 0; write_bits_vd = 0; write_bits_offset = 0; write_bits_instIndex = 0;
    retire_valid = 0; retire_bits_instIndex = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    idle();
  endtask

  task automatic set_alloc(logic vdv, logic [4:0] vd, logic [2:0] tag);
    alloc_valid = 1; alloc_bits_vd_valid = vdv; alloc_bits_vd = vd; alloc_bits_instIndex = tag;
  endtask

  task automatic set_write(logic [4:0] vd, logic [3:0] off, logic [2:0] tag);
    write_valid = 1; write_bits_vd = vd; write_bits_offset = off; write_bits_instIndex = tag;
  endtask

  task automatic set_retire(logic [2:0] tag);
    retire_valid = 1; retire_bits_instIndex = tag;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 0;
    model_clear();
    @(negedge clock);
    #1 reset = 1;
  endtask

  logic [127:0] e;

  initial begin
    idle();
    reset = 0;
    model_clear();
    repeat (2) @(negedge clock);
    #1 reset = 1;
    checking = 1;
    @(negedge clock);
    chk("reset alloc_ready", 128'(alloc_ready), 128'd1);
    chk("reset empty", 128'(empty), 128'd1);
    chk("reset error", 128'(error), 128'd0);
    chk("reset valid", 128'(record_valid), 128'd0);

    // Basic lifecycle
    set_alloc(1, 8, 2); tick();
    chk("life valid", 128'(record_valid), 128'b0001);
    chk("life vd", 128'(record_vd[4:0]), 128'd8);
    chk("life mask0", record_elementMask[127:0], 128'd0);
    set_write(9, 3, 2); tick();
    e = '0; e[19] = 1'b1;
    chk("life mask19", record_elementMask[127:0], e);
    set_retire(2); tick();
    chk("life empty", 128'(empty), 128'd1);
    chk("life error", 128'(error), 128'd0);

    // Independent alloc / write / retire in one cycle
    set_alloc(1, 0, 0); tick();
    set_alloc(1, 2, 1); tick();
    set_alloc(1, 5, 2); set_write(1, 2, 0); set_retire(1); tick();
    set_retire(0); tick();
    set_retire(2); tick();

    // Full and ready timing
    for (int t = 0; t < 4; t++) begin
      set_alloc(1, 5'(4 * t), 3'(t)); tick();
    end
    chk("full ready", 128'(alloc_ready), 128'd0);
    set_alloc(1, 20, 1); set_retire(1); tick();
    chk("full after retire", 128'(record_valid), 128'b1101);
    chk("full ready back", 128'(alloc_ready), 128'd1);
    set_alloc(1, 20, 1); tick();
    chk("full refill", 128'(record_valid), 128'b1111);
    chk("full refill vd", 128'(record_vd[9:5]), 128'd20);
    chk("full error", 128'(error), 128'd0);

    // Window edges
    do_reset();
    set_alloc(1, 4, 0); tick();
    set_write(4, 0, 0); tick();
    set_write(11, 15, 0); tick();
    e = '0; e[0] = 1'b1; e[127] = 1'b1;
    chk("window edges", record_elementMask[127:0], e);
    set_write(12, 0, 0); tick();
    chk("window drop", record_elementMask[127:0], e);
    chk("window error", 128'(error), 128'd1);
    set_alloc(0, 9, 1); tick();
    set_write(9, 1, 1); tick();

    // Same-cycle conflicts
    do_reset();
    set_alloc(1, 2, 5); tick();
    set_write(2, 1, 5); set_retire(5); tick();
    chk("wr+ret valid", 128'(record_valid), 128'd0);
    chk("wr+ret error", 128'(error), 128'd0);
    set_alloc(1, 16, 6); set_write(16, 7, 6); tick();
    e = '0; e[7] = 1'b1;
    chk("alloc+wr mask", record_elementMask[127:0], e);
    chk("alloc+wr error", 128'(error), 128'd0);
    set_alloc(1, 3, 6); set_retire(6); tick();
    chk("reuse valid", 128'(record_valid), 128'b0010);
    chk("reuse error", 128'(error), 128'd0);

    // Protocol errors
    set_retire(7); tick();
    chk("bad retire error", 128'(error), 128'd1);
    chk("bad retire valid", 128'(record_valid), 128'b0010);
    do_reset();
    set_alloc(1, 1, 3); tick();
    set_alloc(1, 2, 3); tick();
    chk("dup error", 128'(error), 128'd1);
    chk("dup valid", 128'(record_valid), 128'b0011);

    // Asynchronous reset mid-cycle
    do_reset();
    for (int t = 1; t < 4; t++) begin
      set_alloc(1, 5'(t), 3'(t)); tick();
    end
    chk("pre-reset valid", 128'(record_valid), 128'b0111);
    @(posedge clock);
    #2 reset = 0;
    #1;
    chk("async valid", 128'(record_valid), 128'd0);
    chk("async empty", 128'(empty), 128'd1);
    chk("async ready", 128'(alloc_ready), 128'd1);
    chk("async mask", record_elementMask[127:0], 128'd0);
    @(negedge clock);
    #1 reset = 1;
    set_alloc(1, 7, 4); tick();
    chk("post-reset slot", 128'(record_valid), 128'b0001);
    chk("post-reset tag", 128'(record_instIndex[2:0]), 128'd4);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
